// File: rtl/packet_parser_if.sv
// Capture bus of the data-island receive path: decoded TERC4 bits in,
// reassembled packet, ECC status, AVI status and counters out.
interface packet_parser_if;
  logic         island_valid;
  logic         header_bit;
  logic [3:0]   sub_lo;
  logic [3:0]   sub_hi;
  logic         video_field_end;
  logic [23:0]  header;
  logic [223:0] sub;
  logic         packet_valid;
  logic         header_ecc_ok;
  logic [3:0]   sub_ecc_ok;
  logic         truncated;
  logic         avi_valid;
  logic [6:0]   avi_vic;
  logic         vic_mismatch;
  logic         avi_missing;
  logic [15:0]  packet_count;
  logic [15:0]  error_count;

  modport master (
    output island_valid, header_bit, sub_lo, sub_hi, video_field_end,
    input  header, sub, packet_valid, header_ecc_ok, sub_ecc_ok, truncated,
           avi_valid, avi_vic, vic_mismatch, avi_missing, packet_count, error_count
  );

  modport slave (
    input  island_valid, header_bit, sub_lo, sub_hi, video_field_end,
    output header, sub, packet_valid, header_ecc_ok, sub_ecc_ok, truncated,
           avi_valid, avi_vic, vic_mismatch, avi_missing, packet_count, error_count
  );
endinterface

// File: rtl/packet_parser.sv
// Reassembles 32-pixel data-island packets, checks BCH parity per block,
// classifies AVI InfoFrames and tracks one AVI per video field.
module packet_parser #(
  parameter logic [6:0] EXPECTED_VIC = 7'd4
) (
  input logic            clk_pixel,
  input logic            reset,
  packet_parser_if.slave bus
);

  typedef enum logic {IDLE, COLLECT} state_t;

  localparam logic [23:0] AVI_HB = 24'h0D0282;

  state_t           state;
  logic [4:0]       k;
  logic [30:0]      hdr_sr;
  logic [3:0][61:0] sub_sr;
  logic [7:0]       e_hdr;
  logic [3:0][7:0]  e_sub;
  logic             field_flag;

  logic [4:0]       pix;
  logic [31:0]      full_hdr;
  logic [3:0][63:0] full_sub;
  logic [7:0]       e_hdr_next;
  logic [3:0][7:0]  e_sub_next;
  logic             hdr_ok;
  logic [3:0]       sub_ok;
  logic             all_ok;
  logic             avi_ok;
  logic [7:0]       csum;

  function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic d);
    return (e >> 1) ^ ((e[0] ^ d) ? 8'h83 : 8'h00);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Current pixel's bits are merged with the shift registers so pixel 31
  // can be judged and latched in the same cycle it arrives.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
    pix        = (state == IDLE) ? 5'd0 : k;
    full_hdr   = {bus.header_bit, hdr_sr};
    e_hdr_next = e_hdr;
    if (pix < 5'd24)
      e_hdr_next = ecc_step((pix == 5'd0) ? 8'h00 : e_hdr, bus.header_bit);
    hdr_ok = (e_hdr == full_hdr[31:24]);
    // NOTE: csum is a running sum inside one combinational pass, so it uses blocking updates.
    csum = full_hdr[7:0] + full_hdr[15:8] + full_hdr[23:16];
    for (int j = 0; j < 4; j++) begin
      full_sub[j]   = {bus.sub_hi[j], bus.sub_lo[j], sub_sr[j]};
      e_sub_next[j] = e_sub[j];
      if (pix < 5'd28)
        e_sub_next[j] = ecc_step(ecc_step((pix == 5'd0) ? 8'h00 : e_sub[j], bus.sub_lo[j]),
                                 bus.sub_hi[j]);
      sub_ok[j] = (e_sub[j] == full_sub[j][63:56]);
      for (int b = 0; b < 7; b++)
        csum = csum + full_sub[j][8*b +: 8];
    end
    all_ok = hdr_ok && (&sub_ok);
    avi_ok = all_ok && (full_hdr[23:0] == AVI_HB) && (csum == 8'h00);
  end

  // NOTE: the capture shift registers are pure datapath, fully refilled by every packet before use, so they carry no reset.
  always_ff @(posedge clk_pixel) begin
    if (bus.island_valid) begin
      hdr_sr <= full_hdr[31:1];
      for (int j = 0; j < 4; j++)
        sub_sr[j] <= full_sub[j][63:2];
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state             <= IDLE;
      k                 <= 5'd0;
      e_hdr             <= 8'h00;
      e_sub             <= '0;
      field_flag        <= 1'b0;
      bus.header        <= '0;
      bus.sub           <= '0;
      bus.packet_valid  <= 1'b0;
      bus.header_ecc_ok <= 1'b0;
      bus.sub_ecc_ok    <= 4'b0000;
      bus.truncated     <= 1'b0;
      bus.avi_valid     <= 1'b0;
      bus.avi_vic       <= 7'd0;
      bus.vic_mismatch  <= 1'b0;
      bus.avi_missing   <= 1'b0;
      bus.packet_count  <= 16'd0;
      bus.error_count   <= 16'd0;
    end else begin
      bus.packet_valid <= 1'b0;
      bus.truncated    <= 1'b0;
      bus.avi_valid    <= 1'b0;
      bus.avi_missing  <= 1'b0;

      if (bus.island_valid) begin
        e_hdr <= e_hdr_next;
        e_sub <= e_sub_next;
      end

      unique case (state)
        IDLE: begin
          if (bus.island_valid) begin
            state <= COLLECT;
            k     <= 5'd1;
          end
        end
        COLLECT: begin
          if (!bus.island_valid) begin
            state           <= IDLE;
            k               <= 5'd0;
            bus.truncated   <= 1'b1;
            bus.error_count <= sat_inc(bus.error_count);
          end else if (k == 5'd31) begin
            // IDLE treats a still-high island_valid as pixel 0, so back-to-back packets need no gap.
            state             <= IDLE;
            k                 <= 5'd0;
            bus.header        <= full_hdr[23:0];
            for (int j = 0; j < 4; j++)
              bus.sub[56*j +: 56] <= full_sub[j][55:0];
            bus.header_ecc_ok <= hdr_ok;
            bus.sub_ecc_ok    <= sub_ok;
            bus.packet_valid  <= 1'b1;
            bus.packet_count  <= sat_inc(bus.packet_count);
            if (!all_ok)
              bus.error_count <= sat_inc(bus.error_count);
            if (avi_ok) begin
              bus.avi_valid    <= 1'b1;
              bus.avi_vic      <= full_sub[0][38:32];
              bus.vic_mismatch <= (full_sub[0][38:32] != EXPECTED_VIC);
            end
          end else begin
            k <= k + 5'd1;
          end
        end
      endcase

      // An AVI pulsing in the same cycle as the field end belongs to the ending field.
      if (bus.video_field_end) begin
        bus.avi_missing <= !(field_flag || bus.avi_valid);
        field_flag      <= 1'b0;
      end else if (bus.avi_valid) begin
        field_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_packet_parser.sv
// Self-checking bench for packet_parser: randomized packets scored against a
// packet-level model built from the BCH, checksum and AVI rules.
module tb_packet_parser;

  localparam logic [6:0] EXP_VIC = 7'd4;

  typedef struct {
    logic [23:0]  header;
    logic [223:0] sub;
    logic         hok;
    logic [3:0]   sok;
    logic         avi;
    int           cyc;
  } pkt_t;

  logic clk_pixel = 1'b0;
  logic reset     = 1'b1;
  int   cyc       = 0;
  int   checks    = 0;
  int   errors    = 0;

  pkt_t got_q[$];
  pkt_t exp_q[$];
  int   trunc_q[$];
  int   missing_cnt = 0;
  int   stray_avi   = 0;
  pkt_t mon_p;

  logic [15:0] exp_pkt = 16'd0;
  logic [15:0] exp_err = 16'd0;
  logic [6:0]  exp_vic = 7'd0;
  logic        exp_mis = 1'b0;

  packet_parser_if bus ();

  packet_parser #(.EXPECTED_VIC(EXP_VIC)) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .bus       (bus.slave)
  );

  always #5 clk_pixel = ~clk_pixel;
  always @(posedge clk_pixel) cyc <= cyc + 1;

  always @(negedge clk_pixel) begin
    if (bus.packet_valid === 1'b1) begin
      mon_p.header = bus.header;
      mon_p.sub    = bus.sub;
      mon_p.hok    = bus.header_ecc_ok;
      mon_p.sok    = bus.sub_ecc_ok;
      mon_p.avi    = bus.avi_valid;
      mon_p.cyc    = cyc;
      got_q.push_back(mon_p);
    end else if (bus.avi_valid === 1'b1) begin
      stray_avi++;
    end
    if (bus.truncated === 1'b1) trunc_q.push_back(cyc);
    if (bus.avi_missing === 1'b1) missing_cnt++;
  end

  function automatic logic [7:0] bch(input logic [63:0] d, input int n);
    logic [7:0] e = 8'h00;
    for (int i = 0; i < n; i++) e = (e >> 1) ^ ((e[0] ^ d[i]) ? 8'h83 : 8'h00);
    return e;
  endfunction

  function automatic logic [223:0] rand_body();
    logic [223:0] b;
    for (int i = 0; i < 7; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  // Random AVI body with PB4 = vic and PB0 chosen so the whole packet sums to zero.
  function automatic logic [223:0] make_avi(input logic [7:0] pb4);
    logic [223:0] b;
    logic [7:0]   s;
    b          = rand_body();
    b[39:32]   = pb4;
    s          = 8'h91;
    for (int i = 1; i < 28; i++) s = s + b[8*i +: 8];
    b[7:0]     = 8'h00 - s;
    return b;
  endfunction

  task automatic model_packet(input logic [31:0] hw, input logic [3:0][63:0] sw, input int when);
    pkt_t       p;
    logic [7:0] s;
    p.header = hw[23:0];
    p.hok    = (bch({40'd0, hw[23:0]}, 24) == hw[31:24]);
    for (int j = 0; j < 4; j++) begin
      p.sub[56*j +: 56] = sw[j][55:0];
      p.sok[j]          = (bch({8'd0, sw[j][55:0]}, 56) == sw[j][63:56]);
    end
    s = hw[7:0] + hw[15:8] + hw[23:16];
    for (int i = 0; i < 28; i++) s = s + p.sub[8*i +: 8];
    p.avi = (hw[23:0] == 24'h0D0282) && p.hok && (p.sok == 4'hF) && (s == 8'h00);
    p.cyc = when;
    exp_q.push_back(p);
    if (exp_pkt != 16'hFFFF) exp_pkt++;
    if (!(p.hok && p.sok == 4'hF) && exp_err != 16'hFFFF) exp_err++;
    if (p.avi) begin
      exp_vic = p.sub[38:32];
      exp_mis = (p.sub[38:32] != EXP_VIC);
    end
  endtask

  task automatic drive(input logic v, input logic h, input logic [3:0] lo,
                       input logic [3:0] hi, input logic fe);
    @(negedge clk_pixel);
    bus.island_valid    = v;
    bus.header_bit      = h;
    bus.sub_lo          = lo;
    bus.sub_hi          = hi;
    bus.video_field_end = fe;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic send_packet(input logic [23:0] hb, input logic [223:0] body,
                             input logic [31:0] hflip, input logic [255:0] sflip,
                             input int npix, output int c0);
    logic [31:0]      hw;
    logic [3:0][63:0] sw;
    logic [3:0]       lo, hi;
    hw = {bch({40'd0, hb}, 24), hb} ^ hflip;
    for (int j = 0; j < 4; j++)
      sw[j] = {bch({8'd0, body[56*j +: 56]}, 56), body[56*j +: 56]} ^ sflip[64*j +: 64];
    c0 = 0;
    for (int p = 0; p < npix; p++) begin
      for (int j = 0; j < 4; j++) begin
        lo[j] = sw[j][2*p];
        hi[j] = sw[j][2*p+1];
      end
      drive(1'b1, hw[p], lo, hi, 1'b0);
      if (p == 0) c0 = cyc;
    end
    if (npix == 32) model_packet(hw, sw, c0 + 32);
  endtask

  task automatic drain_scoreboard(input string name);
    int n;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s packet_count_seen: got %0d packets, expected %0d", name, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_q[i].header !== exp_q[i].header || got_q[i].sub !== exp_q[i].sub ||
          got_q[i].hok !== exp_q[i].hok || got_q[i].sok !== exp_q[i].sok ||
          got_q[i].avi !== exp_q[i].avi || got_q[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL %s pkt%0d: got hdr=%h hok=%b sok=%b avi=%b cyc=%0d sub=%h ; expected hdr=%h hok=%b sok=%b avi=%b cyc=%0d sub=%h",
                 name, i, got_q[i].header, got_q[i].hok, got_q[i].sok, got_q[i].avi, got_q[i].cyc, got_q[i].sub,
                 exp_q[i].header, exp_q[i].hok, exp_q[i].sok, exp_q[i].avi, exp_q[i].cyc, exp_q[i].sub);
      end
    end
    checks++;
    if (bus.packet_count !== exp_pkt || bus.error_count !== exp_err) begin
      errors++;
      $display("FAIL %s counters: got pkt=%0d err=%0d, expected pkt=%0d err=%0d",
               name, bus.packet_count, bus.error_count, exp_pkt, exp_err);
    end
    checks++;
    if (bus.avi_vic !== exp_vic || bus.vic_mismatch !== exp_mis) begin
      errors++;
      $display("FAIL %s avi_status: got vic=%0d mismatch=%b, expected vic=%0d mismatch=%b",
               name, bus.avi_vic, bus.vic_mismatch, exp_vic, exp_mis);
    end
    checks++;
    if (stray_avi != 0 || trunc_q.size() != 0) begin
      errors++;
      $display("FAIL %s stray_pulses: got avi=%0d truncated=%0d, expected 0/0", name, stray_avi, trunc_q.size());
    end
    got_q.delete();
    exp_q.delete();
    trunc_q.delete();
    stray_avi = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2);
    checks++;
    if (bus.header !== 24'd0 || bus.sub !== 224'd0) begin
      errors++;
      $display("FAIL reset_data: got hdr=%h sub=%h, expected zeros", bus.header, bus.sub);
    end
    checks++;
    if ({bus.packet_valid, bus.truncated, bus.avi_valid, bus.avi_missing} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pulses: got pv/tr/avi/miss=%b%b%b%b, expected 0000",
               bus.packet_valid, bus.truncated, bus.avi_valid, bus.avi_missing);
    end
    checks++;
    if (bus.header_ecc_ok !== 1'b0 || bus.sub_ecc_ok !== 4'd0 || bus.avi_vic !== 7'd0 || bus.vic_mismatch !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got hok=%b sok=%b vic=%0d mis=%b, expected 0",
               bus.header_ecc_ok, bus.sub_ecc_ok, bus.avi_vic, bus.vic_mismatch);
    end
    checks++;
    if (bus.packet_count !== 16'd0 || bus.error_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: got pkt=%0d err=%0d, expected 0/0", bus.packet_count, bus.error_count);
    end
    got_q.delete();
    trunc_q.delete();
    stray_avi   = 0;
    missing_cnt = 0;
  endtask

  task automatic test_avi_single();
    int c0;
    send_packet(24'h0D0282, make_avi(8'd4), 32'd0, 256'd0, 32, c0);
    idle(3);
    checks++;
    if (got_q.size() != 1 || got_q[0].avi !== 1'b1 || got_q[0].cyc != c0 + 32 || bus.avi_vic !== 7'd4) begin
      errors++;
      $display("FAIL avi_single: got %0d pulses avi=%b at %0d vic=%0d, expected 1 avi at %0d vic=4",
               got_q.size(), got_q[0].avi, got_q[0].cyc, bus.avi_vic, c0 + 32);
    end
    drain_scoreboard("avi_single");
  endtask

  task automatic test_ecc_errors();
    int            c0;
    logic [255:0]  sflip;
    send_packet(24'h0D0282, make_avi(8'd4), 32'h0400_0000, 256'd0, 32, c0);
    idle(3);
    checks++;
    if (bus.header_ecc_ok !== 1'b0 || got_q.size() != 1 || got_q[0].avi !== 1'b0) begin
      errors++;
      $display("FAIL ecc_header: got hok=%b avi=%b, expected hok=0 avi=0", bus.header_ecc_ok, got_q[0].avi);
    end
    drain_scoreboard("ecc_header");
    sflip          = '0;
    sflip[64*2+60] = 1'b1;
    send_packet(24'h0D0282, make_avi(8'd4), 32'd0, sflip, 32, c0);
    idle(3);
    checks++;
    if (bus.sub_ecc_ok !== 4'b1011 || bus.header_ecc_ok !== 1'b1) begin
      errors++;
      $display("FAIL ecc_sub: got sok=%b hok=%b, expected sok=1011 hok=1", bus.sub_ecc_ok, bus.header_ecc_ok);
    end
    drain_scoreboard("ecc_sub");
  endtask

  task automatic test_back_to_back();
    int c0, c1;
    send_packet(24'd0, 224'd0, 32'd0, 256'd0, 32, c0);
    send_packet(24'd0, 224'd0, 32'd0, 256'd0, 32, c1);
    idle(3);
    checks++;
    if (got_q.size() != 2 || got_q[1].cyc - got_q[0].cyc != 32 || got_q[0].cyc != c0 + 32) begin
      errors++;
      $display("FAIL back_to_back_spacing: got %0d pulses at %0d/%0d, expected 2 at %0d/%0d",
               got_q.size(), got_q[0].cyc, got_q[1].cyc, c0 + 32, c0 + 64);
    end
    drain_scoreboard("back_to_back");
  endtask

  task automatic test_truncation();
    int          c0;
    logic [23:0] hdr_before;
    hdr_before = bus.header;
    send_packet(24'h123456, rand_body(), 32'd0, 256'd0, 20, c0);
    idle(3);
    checks++;
    if (trunc_q.size() != 1 || trunc_q[0] != c0 + 21 || bus.header !== hdr_before) begin
      errors++;
      $display("FAIL truncation: got %0d pulses first at %0d hdr=%h, expected 1 at %0d hdr=%h",
               trunc_q.size(), trunc_q[0], bus.header, c0 + 21, hdr_before);
    end
    trunc_q.delete();
    if (exp_err != 16'hFFFF) exp_err++;
    drain_scoreboard("truncation");
    send_packet(24'h0D0282, make_avi(8'd4), 32'd0, 256'd0, 32, c0);
    idle(3);
    drain_scoreboard("after_truncation");
  endtask

  task automatic test_field();
    int c0;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    idle(3);
    missing_cnt = 0;
    send_packet(24'h000003, rand_body(), 32'd0, 256'd0, 32, c0);
    idle(2);
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    idle(3);
    checks++;
    if (missing_cnt != 1) begin
      errors++;
      $display("FAIL field_no_avi: got %0d avi_missing pulses, expected 1", missing_cnt);
    end
    missing_cnt = 0;
    send_packet(24'h0D0282, make_avi(8'd16), 32'd0, 256'd0, 32, c0);
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    idle(3);
    checks++;
    if (missing_cnt != 0 || bus.vic_mismatch !== 1'b1 || bus.avi_vic !== 7'd16) begin
      errors++;
      $display("FAIL field_avi_vic16: got missing=%0d mismatch=%b vic=%0d, expected 0/1/16",
               missing_cnt, bus.vic_mismatch, bus.avi_vic);
    end
    drain_scoreboard("field_avi");
    missing_cnt = 0;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    idle(3);
    checks++;
    if (missing_cnt != 1) begin
      errors++;
      $display("FAIL field_flag_cleared: got %0d avi_missing pulses, expected 1", missing_cnt);
    end
    missing_cnt = 0;
  endtask

  task automatic test_random();
    int           c0;
    logic [23:0]  hb;
    logic [223:0] body;
    logic [31:0]  hflip;
    logic [255:0] sflip;
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        hb   = 24'h0D0282;
        body = make_avi(8'($urandom_range(0, 255)));
      end else begin
        hb   = 24'($urandom());
        body = rand_body();
      end
      hflip = 32'd0;
      sflip = '0;
      case ($urandom_range(0, 2))
        0:       hflip[$urandom_range(0, 31)] = 1'b1;
        1:       sflip[$urandom_range(0, 255)] = 1'b1;
        default: ;
      endcase
      send_packet(hb, body, hflip, sflip, 32, c0);
      idle($urandom_range(0, 2));
    end
    idle(3);
    drain_scoreboard("random");
  endtask

  task automatic test_reset_mid();
    int c0;
    missing_cnt = 0;
    send_packet(24'h0D0282, make_avi(8'd4), 32'd0, 256'd0, 15, c0);
    @(negedge clk_pixel);
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(3);
    checks++;
    if (got_q.size() != 0 || trunc_q.size() != 0 || stray_avi != 0 || missing_cnt != 0) begin
      errors++;
      $display("FAIL reset_mid_pulses: got pv=%0d tr=%0d avi=%0d miss=%0d, expected none",
               got_q.size(), trunc_q.size(), stray_avi, missing_cnt);
    end
    checks++;
    if (bus.header !== 24'd0 || bus.sub !== 224'd0 || bus.packet_count !== 16'd0 || bus.error_count !== 16'd0 ||
        bus.avi_vic !== 7'd0 || bus.vic_mismatch !== 1'b0 || bus.header_ecc_ok !== 1'b0 || bus.sub_ecc_ok !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_values: got hdr=%h pkt=%0d err=%0d vic=%0d mis=%b hok=%b sok=%b, expected all zero",
               bus.header, bus.packet_count, bus.error_count, bus.avi_vic, bus.vic_mismatch,
               bus.header_ecc_ok, bus.sub_ecc_ok);
    end
    exp_pkt = 16'd0;
    exp_err = 16'd0;
    exp_vic = 7'd0;
    exp_mis = 1'b0;
    got_q.delete();
    trunc_q.delete();
    send_packet(24'h0D0282, make_avi(8'd4), 32'd0, 256'd0, 32, c0);
    idle(3);
    drain_scoreboard("after_reset");
  endtask

  initial begin
    bus.island_valid    = 1'b0;
    bus.header_bit      = 1'b0;
    bus.sub_lo          = 4'h0;
    bus.sub_hi          = 4'h0;
    bus.video_field_end = 1'b0;
    test_reset();
    test_avi_single();
    test_ecc_errors();
    test_back_to_back();
    test_truncation();
    test_field();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
